// File: rtl/sha256_sched_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_sched_ctrl
// Expands one 16-word SHA-256 block into the 64-word message schedule W[0..63]
// by sequencing a shared core ALU (SS0/SS1/ADDU) through a req/gnt port, and
// streams W[t] out in order on a valid/ready interface.
//
// Ports
//   clk, n_reset_i        clock, asynchronous active-low reset
//   start_i               begin a new block (ignored while busy_o=1)
//   busy_o, done_o        busy from accepted start through the done cycle;
//                         done_o pulses once after W[63] is accepted
//   m_data_i/m_valid_i/m_ready_o   message word input, W[0] first
//   w_data_o/w_idx_o/w_valid_o/w_ready_i  schedule word output stream
//   alu_req_o/alu_gnt_i   ALU request / grant (result valid in grant cycle)
//   alu_op_o/alu_rd_o/alu_rs_o     ALU opcode and operands
//   alu_result_i          combinational ALU result
//
// All outputs are registered: their next values are decoded from the
// next-state values (including the buffer after this cycle's write), so they
// appear in the same cycle a decoded output would, without glitches.
// -----------------------------------------------------------------------------
module sha256_sched_ctrl #(
  parameter int unsigned     OP_W    = 16,
  parameter logic [OP_W-1:0] OP_ADDU = OP_W'(1),
  parameter logic [OP_W-1:0] OP_SS0  = OP_W'(2),
  parameter logic [OP_W-1:0] OP_SS1  = OP_W'(3)
) (
  input  logic            clk,
  input  logic            n_reset_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  input  logic [31:0]     m_data_i,
  input  logic            m_valid_i,
  output logic            m_ready_o,
  output logic [31:0]     w_data_o,
  output logic [5:0]      w_idx_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic            alu_req_o,
  input  logic            alu_gnt_i,
  output logic [OP_W-1:0] alu_op_o,
  output logic [31:0]     alu_rd_o,
  output logic [31:0]     alu_rs_o,
  input  logic [31:0]     alu_result_i
);

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 6;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_S1,
    S_A1,
    S_S0,
    S_A2,
    S_A3
  } state_e;

  // Control state
  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   tmp_q, tmp_d;

  // Registered outputs
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            m_ready_q, m_ready_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [TW-1:0]   w_idx_q, w_idx_d;
  logic            w_valid_q, w_valid_d;
  logic            alu_req_q, alu_req_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [DW-1:0]   alu_rd_q, alu_rd_d;
  logic [DW-1:0]   alu_rs_q, alu_rs_d;

  // Circular schedule buffer: W[t] lives at mem_q[t mod 16]
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_nxt [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic [AW-1:0]   tn;

  // Next-state, buffer write and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    acc_d     = acc_q;
    tmp_d     = tmp_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = m_data_i;

    unique case (state_q)
      S_IDLE: begin
        // busy_q is still high during the done cycle, so a start there is dropped
        if (start_i && !busy_q) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          t_d     = '0;
        end
      end
      S_LOAD: begin
        if (m_valid_i) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = m_data_i;
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = S_EMIT;
            t_d     = '0;
          end
        end
      end
      S_EMIT: begin
        if (w_ready_i) begin
          if (t_q == TW'(63)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            t_d     = t_q + TW'(1);
            state_d = (t_q < TW'(DEPTH - 1)) ? S_EMIT : S_S1;
          end
        end
      end
      S_S1: begin
        if (alu_gnt_i) begin
          acc_d   = alu_result_i;
          state_d = S_A1;
        end
      end
      S_A1: begin
        if (alu_gnt_i) begin
          acc_d   = alu_result_i;
          state_d = S_S0;
        end
      end
      S_S0: begin
        if (alu_gnt_i) begin
          tmp_d   = alu_result_i;
          state_d = S_A2;
        end
      end
      S_A2: begin
        if (alu_gnt_i) begin
          acc_d   = alu_result_i;
          state_d = S_A3;
        end
      end
      S_A3: begin
        // W[t] replaces W[t-16], which was the rs operand of this very op
        if (alu_gnt_i) begin
          mem_we    = 1'b1;
          mem_waddr = t_q[AW-1:0];
          mem_wdata = alu_result_i;
          state_d   = S_EMIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Buffer as it will look after this edge, so outputs see fresh writes
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_nxt[i] = mem_q[i];
    end
    if (mem_we) begin
      mem_nxt[mem_waddr] = mem_wdata;
    end

    busy_d    = (state_d != S_IDLE) || done_d;
    m_ready_d = (state_d == S_LOAD);
    w_valid_d = 1'b0;
    w_data_d  = '0;
    w_idx_d   = '0;
    alu_req_d = 1'b0;
    alu_op_d  = '0;
    alu_rd_d  = '0;
    alu_rs_d  = '0;
    tn        = t_d[AW-1:0];

    unique case (state_d)
      S_EMIT: begin
        w_valid_d = 1'b1;
        w_data_d  = mem_nxt[tn];
        w_idx_d   = t_d;
      end
      S_S1: begin
        alu_req_d = 1'b1;
        alu_op_d  = OP_SS1;
        alu_rs_d  = mem_nxt[tn - AW'(2)];
      end
      S_A1: begin
        alu_req_d = 1'b1;
        alu_op_d  = OP_ADDU;
        alu_rd_d  = acc_d;
        alu_rs_d  = mem_nxt[tn - AW'(7)];
      end
      S_S0: begin
        alu_req_d = 1'b1;
        alu_op_d  = OP_SS0;
        alu_rs_d  = mem_nxt[tn - AW'(15)];
      end
      S_A2: begin
        alu_req_d = 1'b1;
        alu_op_d  = OP_ADDU;
        alu_rd_d  = acc_d;
        alu_rs_d  = tmp_d;
      end
      S_A3: begin
        // t-16 and t share the same slot modulo 16
        alu_req_d = 1'b1;
        alu_op_d  = OP_ADDU;
        alu_rd_d  = acc_d;
        alu_rs_d  = mem_nxt[tn];
      end
      default: begin
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      t_q       <= '0;
      acc_q     <= '0;
      tmp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_ready_q <= 1'b0;
      w_data_q  <= '0;
      w_idx_q   <= '0;
      w_valid_q <= 1'b0;
      alu_req_q <= 1'b0;
      alu_op_q  <= '0;
      alu_rd_q  <= '0;
      alu_rs_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      acc_q     <= acc_d;
      tmp_q     <= tmp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_ready_q <= m_ready_d;
      w_data_q  <= w_data_d;
      w_idx_q   <= w_idx_d;
      w_valid_q <= w_valid_d;
      alu_req_q <= alu_req_d;
      alu_op_q  <= alu_op_d;
      alu_rd_q  <= alu_rd_d;
      alu_rs_q  <= alu_rs_d;
    end
  end

  // Buffer storage; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign m_ready_o = m_ready_q;
  assign w_data_o  = w_data_q;
  assign w_idx_o   = w_idx_q;
  assign w_valid_o = w_valid_q;
  assign alu_req_o = alu_req_q;
  assign alu_op_o  = alu_op_q;
  assign alu_rd_o  = alu_rd_q;
  assign alu_rs_o  = alu_rs_q;

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha256_sched_ctrl
// Directed bench for sha256_sched_ctrl with a behavioural SS0/SS1/ADDU ALU and
// a reference SHA-256 schedule expansion for the expected W stream.
// -----------------------------------------------------------------------------
module tb_sha256_sched_ctrl;

  logic        clk = 1'b0;
  logic        n_reset_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] m_data_i;
  logic        m_valid_i;
  logic        m_ready_o;
  logic [31:0] w_data_o;
  logic [5:0]  w_idx_o;
  logic        w_valid_o;
  logic        w_ready_i;
  logic        alu_req_o;
  logic        alu_gnt_i;
  logic [15:0] alu_op_o;
  logic [31:0] alu_rd_o;
  logic [31:0] alu_rs_o;
  logic [31:0] alu_result_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] blk  [16];
  logic [31:0] wexp [64];
  logic [31:0] got  [64];

  bit   gnt_rand = 1'b0;
  bit   mon_en   = 1'b0;
  logic req_prev = 1'b0;

  sha256_sched_ctrl dut (
    .clk          (clk),
    .n_reset_i    (n_reset_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .m_data_i     (m_data_i),
    .m_valid_i    (m_valid_i),
    .m_ready_o    (m_ready_o),
    .w_data_o     (w_data_o),
    .w_idx_o      (w_idx_o),
    .w_valid_o    (w_valid_o),
    .w_ready_i    (w_ready_i),
    .alu_req_o    (alu_req_o),
    .alu_gnt_i    (alu_gnt_i),
    .alu_op_o     (alu_op_o),
    .alu_rd_o     (alu_rd_o),
    .alu_rs_o     (alu_rs_o),
    .alu_result_i (alu_result_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Behavioural core ALU
  always_comb begin
    case (alu_op_o)
      16'h0001: alu_result_i = alu_rd_o + alu_rs_o;
      16'h0002: alu_result_i = ss0(alu_rs_o);
      16'h0003: alu_result_i = ss1(alu_rs_o);
      default:  alu_result_i = 32'h0;
    endcase
  end

  // Grant: always on, or a fair coin per cycle
  always @(negedge clk) begin
    alu_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request may only fall when the finished word is presented
  always @(negedge clk) begin
    if (mon_en) begin
      if (req_prev && !alu_req_o) chk("req_drop_mid_word", 64'(w_valid_o), 64'd1);
      chk("req_and_valid", 64'(alu_req_o & w_valid_o), 64'd0);
    end
    req_prev = alu_req_o;
  end

  task automatic build_sched();
    for (int i = 0; i < 16; i++) wexp[i] = blk[i];
    for (int i = 16; i < 64; i++)
      wexp[i] = ss1(wexp[i-2]) + wexp[i-7] + ss0(wexp[i-15]) + wexp[i-16];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    64'(busy_o),    64'd0);
    chk({tag, "_done"},    64'(done_o),    64'd0);
    chk({tag, "_m_ready"}, 64'(m_ready_o), 64'd0);
    chk({tag, "_w_valid"}, 64'(w_valid_o), 64'd0);
    chk({tag, "_w_data"},  64'(w_data_o),  64'd0);
    chk({tag, "_w_idx"},   64'(w_idx_o),   64'd0);
    chk({tag, "_alu_req"}, 64'(alu_req_o), 64'd0);
    chk({tag, "_alu_op"},  64'(alu_op_o),  64'd0);
    chk({tag, "_alu_rd"},  64'(alu_rd_o),  64'd0);
    chk({tag, "_alu_rs"},  64'(alu_rs_o),  64'd0);
  endtask

  // Runs one block from the current negedge. e counts edges after the edge
  // that samples start_i; done_o is expected after edge 320 (cycle 321).
  task automatic run_block(input int stall_at, input bit poke, input int abort_at,
                           input bit chk_lat);
    int k = 0;
    int tx = 0;
    int e = 0;
    int stall_n = 0;
    bit fin = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    while (!fin && e < 4000) begin
      if (abort_at >= 0 && tx == abort_at) begin
        n_reset_i = 1'b0;
        m_valid_i = 1'b0;
        start_i   = 1'b0;
        #1;
        chk_zero("async_reset");
        fin = 1'b1;
      end else if (done_o) begin
        if (chk_lat) chk("done_latency", 64'(e), 64'd320);
        chk("done_word_count", 64'(tx), 64'd64);
        chk("busy_in_done", 64'(busy_o), 64'd1);
        fin = 1'b1;
      end else begin
        start_i = poke && (e == 150);
        if (m_ready_o && k < 16) begin
          m_valid_i = 1'b1;
          m_data_i  = blk[k];
          k++;
        end else begin
          m_valid_i = poke;
          m_data_i  = poke ? 32'hDEADBEEF : 32'h0;
        end
        if (w_valid_o && tx == stall_at && stall_n < 10) begin
          w_ready_i = 1'b0;
          stall_n++;
          chk("stall_idx",   64'(w_idx_o),   64'(stall_at));
          chk("stall_data",  64'(w_data_o),  64'(wexp[stall_at]));
          chk("stall_noreq", 64'(alu_req_o), 64'd0);
        end else begin
          w_ready_i = 1'b1;
        end
        if (w_valid_o && w_ready_i) begin
          chk("w_idx",  64'(w_idx_o),  64'(tx));
          chk("w_data", 64'(w_data_o), 64'(wexp[tx]));
          got[tx] = w_data_o;
          tx++;
        end
      end
      if (!fin) begin
        @(negedge clk);
        e++;
      end
    end
    chk("block_finished", 64'(fin), 64'd1);
    m_valid_i = 1'b0;
    m_data_i  = 32'h0;
    w_ready_i = 1'b1;
    start_i   = 1'b0;
  endtask

  task automatic chk_after_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    chk({tag, "_busy_clear"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    n_reset_i = 1'b0;
    start_i   = 1'b0;
    m_data_i  = 32'h0;
    m_valid_i = 1'b0;
    w_ready_i = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    n_reset_i = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy_o), 64'd0);

    // 1: "abc" block, full grant and ready, latency and known schedule words
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_sched();
    mon_en = 1'b1;
    run_block(-1, 1'b0, -1, 1'b1);
    chk("abc_w16", 64'(got[16]), 64'h61626380);
    chk("abc_w17", 64'(got[17]), 64'h000F0000);
    chk("abc_w63", 64'(got[63]), 64'h12B1EDEB);
    chk_after_done("t1");

    // 2: random 50% grant, identical stream
    gnt_rand = 1'b1;
    run_block(-1, 1'b0, -1, 1'b0);
    gnt_rand = 1'b0;
    chk("rand_w63", 64'(got[63]), 64'h12B1EDEB);
    chk_after_done("t2");

    // 3: downstream holds off W20 for 10 cycles
    run_block(20, 1'b0, -1, 1'b0);
    chk_after_done("t3");

    // 4: stray start and m_valid mid-block are ignored, latency unchanged
    run_block(-1, 1'b1, -1, 1'b1);
    chk_after_done("t4");

    // 5: reset at t=30, outputs stay cleared, then a clean block
    mon_en = 1'b0;
    run_block(-1, 1'b0, 30, 1'b0);
    @(negedge clk);
    chk_zero("held_reset");
    n_reset_i = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 64'(busy_o), 64'd0);
    chk("post_reset_done", 64'(done_o), 64'd0);
    mon_en = 1'b1;
    run_block(-1, 1'b0, -1, 1'b1);
    chk_after_done("t5");

    // 6: all-ones blocks back to back (start in the cycle after done)
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    build_sched();
    run_block(-1, 1'b0, -1, 1'b1);
    chk_after_done("t6a");
    run_block(-1, 1'b0, -1, 1'b1);
    chk_after_done("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
